// File: rtl/note_judge_pkg.sv
// note_judge_pkg
//   Definitions shared by the note-lane blocks: the note judge, the shifter and
//   the display decoder.
//   - grade_t    : grade encoding carried on the grade bus.
//   - state_t    : play-state encoding for the judge FSM.
//   - PERFECT_LO / PERFECT_HI : inclusive offset window that earns a PERFECT.
//   - judge_press: grades one press against the notes in the judge column.
package note_judge_pkg;

    typedef enum logic [1:0] {
        GR_NONE    = 2'd0,
        GR_PERFECT = 2'd1,
        GR_GOOD    = 2'd2,
        GR_MISS    = 2'd3
    } grade_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam logic [2:0] PERFECT_LO = 3'd2;
    localparam logic [2:0] PERFECT_HI = 3'd4;

    // Grade a press against the column contents. The caller decides whether
    // the note is still available (hit_lock). Returns GR_NONE when nothing is
    // pressed or the column is empty.
    function automatic grade_t judge_press(
        input logic       press_r,
        input logic       press_b,
        input logic       note_r,
        input logic       note_b,
        input logic [2:0] off
    );
        grade_t g;
        logic   in_window;
        in_window = (off >= PERFECT_LO) && (off <= PERFECT_HI);
        g = GR_NONE;
        if ((note_r || note_b) && (press_r || press_b)) begin
            if (press_r && press_b) begin
                // Mashing both buttons is never rewarded.
                g = GR_MISS;
            end else if ((press_r && note_r) || (press_b && note_b)) begin
                g = in_window ? GR_PERFECT : GR_GOOD;
            end else begin
                g = GR_MISS;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/note_judge_btn_sync.sv
// btn_sync_edge
//   Brings one debounced player button into the clk domain and produces a
//   single-cycle pulse on its rising edge. The pulse appears three clock edges
//   after the pin rises (two synchronizer flops plus the registered edge).
// Ports
//   clk   in  1  system clock
//   rst_n in  1  async active-low reset
//   btn   in  1  button pin, asynchronous to clk
//   press out 1  one-cycle pulse on a synchronized rising edge
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic sync_2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_2_q <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_1   <= btn;
            sync_2   <= sync_1;
            sync_2_q <= sync_2;
            press    <= sync_2 && !sync_2_q;
        end
    end

endmodule

// File: rtl/note_judge.sv
// note_judge
//   Player-side end of the note lane. Grades each note in the judge column as
//   PERFECT / GOOD / MISS from the two player buttons, keeps score, combo and
//   best combo, and returns a one-cycle delete so the shifter clears a hit note.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | after reset, waiting for the first song_start
//   ST_PLAY   | song running; presses are judged, misses on column advance
//   ST_RESULT | song finished; score and max_combo held for display
//
// Ports
//   clk          in  1        system clock
//   rst_n        in  1        async active-low reset
//   song_start   in  1        pulse: begin play, clear score/combo/max_combo
//   finish       in  1        pulse from shifter: song ended
//   note_R_judge in  1        red note present in judge column
//   note_B_judge in  1        blue note present in judge column
//   offset       in  3        shifter pixel counter
//   btn_R        in  1        red button, async to clk
//   btn_B        in  1        blue button, async to clk
//   delete       out 1        pulse: clear judge-column note
//   grade_valid  out 1        pulse: grade is valid
//   grade        out 2        0 NONE, 1 PERFECT, 2 GOOD, 3 MISS
//   score        out SCORE_W  accumulated score (saturating)
//   combo        out COMBO_W  consecutive hits (saturating)
//   max_combo    out COMBO_W  best combo this song
//   playing      out 1        high in ST_PLAY
module note_judge
    import note_judge_pkg::*;
#(
    parameter int SCORE_W     = 14,
    parameter int COMBO_W     = 8,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1,
    parameter int OFFSET_LAST = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               song_start,
    input  logic               finish,
    input  logic               note_R_judge,
    input  logic               note_B_judge,
    input  logic [2:0]         offset,
    input  logic               btn_R,
    input  logic               btn_B,
    output logic               delete,
    output logic               grade_valid,
    output logic [1:0]         grade,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic               playing
);

    localparam logic [SCORE_W:0] PERFECT_INC = (SCORE_W+1)'(PERFECT_PTS);
    localparam logic [SCORE_W:0] GOOD_INC    = (SCORE_W+1)'(GOOD_PTS);
    localparam logic [2:0]       OFF_LAST    = 3'(OFFSET_LAST);

    logic press_r;
    logic press_b;

    btn_sync_edge u_sync_r (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_R),
        .press (press_r)
    );

    btn_sync_edge u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_B),
        .press (press_b)
    );

    state_t     state;
    logic [2:0] offset_q;
    logic       note_r_q;
    logic       note_b_q;
    logic       hit_lock;

    logic               adv;
    logic               cand_r;
    logic               cand_b;
    grade_t             hit_g;
    logic               hit;
    logic               miss_adv;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [COMBO_W-1:0] combo_next;
    logic [COMBO_W-1:0] max_next;

    always_comb begin
        adv = (offset_q == OFF_LAST) && (offset == 3'd0);
        // On the advance cycle the flags already show the incoming column, so a
        // press landing there is judged against the departing note (last cycle's
        // flags). That same press then consumes the departing note, which also
        // suppresses the advance miss below.
        cand_r   = adv ? note_r_q : note_R_judge;
        cand_b   = adv ? note_b_q : note_B_judge;
        hit_g    = judge_press(press_r, press_b, cand_r, cand_b, offset);
        hit      = !hit_lock && (hit_g != GR_NONE);
        miss_adv = adv && (note_r_q || note_b_q) && !hit_lock && !hit;

        score_sum  = {1'b0, score} + ((hit_g == GR_PERFECT) ? PERFECT_INC : GOOD_INC);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        combo_next = (combo == '1) ? combo : combo + COMBO_W'(1);
        max_next   = (combo_next > max_combo) ? combo_next : max_combo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            offset_q    <= 3'd0;
            note_r_q    <= 1'b0;
            note_b_q    <= 1'b0;
            hit_lock    <= 1'b0;
            delete      <= 1'b0;
            grade_valid <= 1'b0;
            grade       <= GR_NONE;
            score       <= '0;
            combo       <= '0;
            max_combo   <= '0;
            playing     <= 1'b0;
        end else begin
            offset_q    <= offset;
            note_r_q    <= note_R_judge;
            note_b_q    <= note_B_judge;
            delete      <= 1'b0;
            grade_valid <= 1'b0;
            grade       <= GR_NONE;

            unique case (state)
                ST_IDLE, ST_RESULT: begin
                    if (song_start) begin
                        state     <= ST_PLAY;
                        playing   <= 1'b1;
                        hit_lock  <= 1'b0;
                        score     <= '0;
                        combo     <= '0;
                        max_combo <= '0;
                    end
                end

                ST_PLAY: begin
                    if (song_start) begin
                        // Restart: the clear wins over anything judged this cycle.
                        hit_lock  <= 1'b0;
                        score     <= '0;
                        combo     <= '0;
                        max_combo <= '0;
                    end else begin
                        if (hit) begin
                            delete      <= 1'b1;
                            grade_valid <= 1'b1;
                            grade       <= hit_g;
                            if (hit_g == GR_MISS) begin
                                combo <= '0;
                            end else begin
                                score     <= score_next;
                                combo     <= combo_next;
                                max_combo <= max_next;
                            end
                        end else if (miss_adv) begin
                            grade_valid <= 1'b1;
                            grade       <= GR_MISS;
                            combo       <= '0;
                        end

                        if (adv) begin
                            hit_lock <= 1'b0;
                        end else if (hit) begin
                            hit_lock <= 1'b1;
                        end

                        if (finish) begin
                            state   <= ST_RESULT;
                            playing <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_judge.sv
// Randomized bench for note_judge with a column-level reference model.
module tb_note_judge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        song_start;
    logic        finish;
    logic        note_R_judge;
    logic        note_B_judge;
    logic [2:0]  offset;
    logic        btn_R;
    logic        btn_B;
    logic        delete;
    logic        grade_valid;
    logic [1:0]  grade;
    logic [13:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic        playing;

    always #5 clk = ~clk;

    note_judge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .song_start   (song_start),
        .finish       (finish),
        .note_R_judge (note_R_judge),
        .note_B_judge (note_B_judge),
        .offset       (offset),
        .btn_R        (btn_R),
        .btn_B        (btn_B),
        .delete       (delete),
        .grade_valid  (grade_valid),
        .grade        (grade),
        .score        (score),
        .combo        (combo),
        .max_combo    (max_combo),
        .playing      (playing)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a song is a stream of columns; each button press is
    // seen by the judge three cycles after the pin rises.
    bit m_play;
    int m_score, m_combo, m_max;
    bit m_lock;
    int m_prev_off;
    bit m_prev_r, m_prev_b;
    bit hist_r[4];
    bit hist_b[4];
    int e_del, e_gv, e_gr;

    // Stimulus state
    int cur_off   = 0;
    int hold_left = 0;
    bit col_r     = 1'b0;
    bit col_b     = 1'b0;

    task automatic model_reset();
        m_play = 0; m_score = 0; m_combo = 0; m_max = 0; m_lock = 0;
        m_prev_off = 0; m_prev_r = 0; m_prev_b = 0;
        for (int i = 0; i < 4; i++) begin hist_r[i] = 0; hist_b[i] = 0; end
        e_del = 0; e_gv = 0; e_gr = 0;
    endtask

    task automatic model_clear();
        m_score = 0; m_combo = 0; m_max = 0; m_lock = 0;
    endtask

    task automatic model_step();
        bit pr, pb, adv, r, b;
        int g;
        int off;
        off = int'(offset);
        pr  = hist_r[2] && !hist_r[3];
        pb  = hist_b[2] && !hist_b[3];
        adv = (m_prev_off == 6) && (off == 0);
        e_del = 0; e_gv = 0; e_gr = 0;
        if (m_play) begin
            if (song_start) begin
                model_clear();
            end else begin
                r = adv ? m_prev_r : note_R_judge;
                b = adv ? m_prev_b : note_B_judge;
                g = 0;
                if ((r || b) && !m_lock && (pr || pb)) begin
                    if (pr && pb)                      g = 3;
                    else if ((pr && r) || (pb && b))   g = (off >= 2 && off <= 4) ? 1 : 2;
                    else                               g = 3;
                end
                if (g != 0) begin
                    e_del = 1; e_gv = 1; e_gr = g;
                    if (g == 3) begin
                        m_combo = 0;
                    end else begin
                        m_score = m_score + ((g == 1) ? 3 : 1);
                        if (m_score > 16383) m_score = 16383;
                        if (m_combo < 255) m_combo++;
                        if (m_combo > m_max) m_max = m_combo;
                    end
                end else if (adv && (m_prev_r || m_prev_b) && !m_lock) begin
                    e_gv = 1; e_gr = 3; m_combo = 0;
                end
                if (adv) m_lock = 0;
                else if (g != 0) m_lock = 1;
                if (finish) m_play = 0;
            end
        end else if (song_start) begin
            m_play = 1;
            model_clear();
        end
        for (int i = 3; i > 0; i--) begin
            hist_r[i] = hist_r[i-1];
            hist_b[i] = hist_b[i-1];
        end
        hist_r[0] = btn_R;
        hist_b[0] = btn_B;
        m_prev_off = off;
        m_prev_r   = note_R_judge;
        m_prev_b   = note_B_judge;
    endtask

    task automatic compare_all();
        check("delete",      int'(delete),      e_del);
        check("grade_valid", int'(grade_valid), e_gv);
        check("grade",       int'(grade),       e_gr);
        check("score",       int'(score),       m_score);
        check("combo",       int'(combo),       m_combo);
        check("max_combo",   int'(max_combo),   m_max);
        check("playing",     int'(playing),     int'(m_play));
    endtask

    // mode 0: random columns, buttons and song control
    // mode 1: one red note per column, clean red press landing at offset 3
    task automatic gen_inputs(input int mode);
        int k;
        song_start = 1'b0;
        finish     = 1'b0;
        if (e_del != 0) begin col_r = 0; col_b = 0; end
        if (mode == 0) begin
            if (hold_left == 0) begin
                cur_off   = (cur_off == 6) ? 0 : cur_off + 1;
                hold_left = $urandom_range(0, 2);
                if (cur_off == 0) begin
                    k = $urandom_range(0, 9);
                    col_r = (k >= 3 && k <= 5) || (k == 9);
                    col_b = (k >= 6);
                end
            end else begin
                hold_left--;
            end
            if ($urandom_range(0, 5) == 0) btn_R = ~btn_R;
            if ($urandom_range(0, 5) == 0) btn_B = ~btn_B;
            if (!m_play) begin
                song_start = ($urandom_range(0, 19) == 0);
            end else begin
                song_start = ($urandom_range(0, 599) == 0);
                finish     = ($urandom_range(0, 299) == 0);
            end
        end else begin
            cur_off = (cur_off == 6) ? 0 : cur_off + 1;
            if (cur_off == 0) begin col_r = 1; col_b = 0; end
            btn_R = (cur_off <= 2);
            btn_B = 1'b0;
        end
        offset       = 3'(cur_off);
        note_R_judge = col_r;
        note_B_judge = col_b;
    endtask

    task automatic run_cycles(input int n, input int mode, input bit first_start,
                              input bit first_finish);
        for (int i = 0; i < n; i++) begin
            gen_inputs(mode);
            if (i == 0 && first_start)  song_start = 1'b1;
            if (i == 0 && first_finish) finish     = 1'b1;
            model_step();
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_delete"},      int'(delete),      0);
        check({phase, "_grade_valid"}, int'(grade_valid), 0);
        check({phase, "_grade"},       int'(grade),       0);
        check({phase, "_score"},       int'(score),       0);
        check({phase, "_combo"},       int'(combo),       0);
        check({phase, "_max_combo"},   int'(max_combo),   0);
        check({phase, "_playing"},     int'(playing),     0);
    endtask

    initial begin
        rst_n = 1'b0;
        song_start = 0; finish = 0; note_R_judge = 0; note_B_judge = 0;
        offset = 3'd0; btn_R = 0; btn_B = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_cycles(1500, 0, 1'b1, 1'b0);

        // Score something, then pull reset between clock edges.
        run_cycles(40, 1, 1'b1, 1'b0);
        check("pre_reset_score_nonzero", int'(score != 14'd0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        run_cycles(1000, 0, 1'b0, 1'b0);

        // Long clean run: combo saturates at 255, score at 16383.
        run_cycles(5470 * 7, 1, 1'b1, 1'b0);
        check("score_saturated", int'(score), 16383);
        check("combo_saturated", int'(combo), 255);
        check("max_saturated",   int'(max_combo), 255);

        // Finish, then keep pressing: nothing may change in RESULT.
        run_cycles(1, 1, 1'b0, 1'b1);
        run_cycles(35, 1, 1'b0, 1'b0);
        check("result_playing", int'(playing), 0);
        check("result_score",   int'(score), 16383);

        run_cycles(1500, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
